regfile_bist: RTL and testbench

Synthesizable built-in self-test controller that drives the write side and both read ports of the 32x32 two-read/one-write register file, then checks what comes back. On Start it runs a fixed six-phase march:
- write a pattern, read it back;
- write the inverse, read it back;
- attempt writes with RegWrite low, confirm the contents are unchanged.
It reports Done, Passed and first-failure diagnostics. It sits beside the register file in the datapath and muxes onto the register file ports during test.

---
 rtl/regfile_bist_pkg.sv | 43 ++++
 rtl/regfile_bist_check.sv | 77 +++++++
 rtl/regfile_bist.sv | 169 ++++++++++++++++
 tb/tb_regfile_bist.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_bist_pkg.sv
// Shared types and helpers for the register-file march BIST controller.
package regfile_bist_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   localparam logic [2:0] PH_WR_A    = 3'd0;
   localparam logic [2:0] PH_RD_A    = 3'd1;
   localparam logic [2:0] PH_WR_B    = 3'd2;
   localparam logic [2:0] PH_RD_B    = 3'd3;
   localparam logic [2:0] PH_WR_HOLD = 3'd4;
   localparam logic [2:0] PH_RD_HOLD = 3'd5;

   // Phase states carry their phase code so FailPhase is just the state value.
   typedef enum logic [2:0] {
      ST_WR_A    = PH_WR_A,
      ST_RD_A    = PH_RD_A,
      ST_WR_B    = PH_WR_B,
      ST_RD_B    = PH_RD_B,
      ST_WR_HOLD = PH_WR_HOLD,
      ST_RD_HOLD = PH_RD_HOLD,
      ST_IDLE    = 3'd6,
      ST_DONE    = 3'd7
   } state_e;

   function automatic logic [DATA_W-1:0] pattern_a(input logic [ADDR_W-1:0] i,
                                                   input logic [DATA_W-1:0] seed);
      return seed ^ {i, 22'b0, i};
   endfunction

   function automatic state_e next_phase(input state_e s);
      case (s)
         ST_WR_A:    return ST_RD_A;
         ST_RD_A:    return ST_WR_B;
         ST_WR_B:    return ST_RD_B;
         ST_RD_B:    return ST_WR_HOLD;
         ST_WR_HOLD: return ST_RD_HOLD;
         default:    return ST_DONE;
      endcase
   endfunction

endpackage

// File: rtl/regfile_bist_check.sv
// Read-port comparators plus first-failure capture for the register-file BIST.
module regfile_bist_check
   import regfile_bist_pkg::*;
#(
   parameter bit CHECK_ZERO_REG = 1'b1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              cmp_en,
   input  logic [2:0]        phase,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic [DATA_W-1:0] rd_data2,
   input  logic [DATA_W-1:0] exp1,
   input  logic [DATA_W-1:0] exp2,
   output logic              mismatch1,
   output logic              mismatch2,
   output logic              fail_seen,
   output logic [2:0]        fail_phase,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              fail_port
);

   logic [DATA_W-1:0] exp1_eff, exp2_eff;
   logic              fail_seen_d, fail_seen_q;
   logic [2:0]        fail_phase_d, fail_phase_q;
   logic [ADDR_W-1:0] fail_addr_d, fail_addr_q;
   logic              fail_port_d, fail_port_q;

   // r0 is expected to read zero; when not checked it is skipped entirely.
   always_comb begin
      exp1_eff  = (addr1 == '0) ? '0 : exp1;
      exp2_eff  = (addr2 == '0) ? '0 : exp2;
      mismatch1 = cmp_en && (CHECK_ZERO_REG || (addr1 != '0)) && (rd_data1 != exp1_eff);
      mismatch2 = cmp_en && (CHECK_ZERO_REG || (addr2 != '0)) && (rd_data2 != exp2_eff);
   end

   always_comb begin
      fail_seen_d  = fail_seen_q;
      fail_phase_d = fail_phase_q;
      fail_addr_d  = fail_addr_q;
      fail_port_d  = fail_port_q;
      if (clear) begin
         fail_seen_d  = 1'b0;
         fail_phase_d = '0;
         fail_addr_d  = '0;
         fail_port_d  = 1'b0;
      end else if (!fail_seen_q && (mismatch1 || mismatch2)) begin
         fail_seen_d  = 1'b1;
         fail_phase_d = phase;
         fail_addr_d  = mismatch1 ? addr1 : addr2;
         fail_port_d  = !mismatch1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fail_seen_q  <= 1'b0;
         fail_phase_q <= '0;
         fail_addr_q  <= '0;
         fail_port_q  <= 1'b0;
      end else begin
         fail_seen_q  <= fail_seen_d;
         fail_phase_q <= fail_phase_d;
         fail_addr_q  <= fail_addr_d;
         fail_port_q  <= fail_port_d;
      end
   end

   assign fail_seen  = fail_seen_q;
   assign fail_phase = fail_phase_q;
   assign fail_addr  = fail_addr_q;
   assign fail_port  = fail_port_q;

endmodule

// File: rtl/regfile_bist.sv
// Six-phase march BIST for the 32x32 2R1W register file; drives its ports and
// reports pass/fail with first-failure diagnostics.
module regfile_bist
   import regfile_bist_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED           = 32'hA5C3_0F96,
   parameter bit                CHECK_ZERO_REG = 1'b1,
   parameter bit                STOP_ON_FAIL   = 1'b0
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic              Busy,
   output logic              Done,
   output logic              Passed,
   output logic [2:0]        FailPhase,
   output logic [ADDR_W-1:0] FailAddr,
   output logic              FailPort,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] WriteData,
   output logic [ADDR_W-1:0] ReadRegister1,
   output logic [ADDR_W-1:0] ReadRegister2,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic              RegWrite
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_e            state_d, state_q, nxt_state;
   logic [ADDR_W-1:0] idx_d, idx_q, nxt_idx;
   logic              busy_d, busy_q, done_d, done_q, passed_d, passed_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic [ADDR_W-1:0] rreg1_d, rreg1_q, rreg2_d, rreg2_q, wreg_d, wreg_q;
   logic              regwrite_d, regwrite_q;
   logic              launch, cmp_en, mismatch1, mismatch2, fail_seen;
   logic [DATA_W-1:0] exp1, exp2;

   // Read addresses are registered, so the data present now belongs to rreg*_q.
   always_comb begin
      cmp_en = (state_q == ST_RD_A) || (state_q == ST_RD_B) || (state_q == ST_RD_HOLD);
      exp1   = pattern_a(rreg1_q, SEED);
      exp2   = pattern_a(rreg2_q, SEED);
      if (state_q != ST_RD_A) begin
         exp1 = ~exp1;
         exp2 = ~exp2;
      end
   end

   regfile_bist_check #(.CHECK_ZERO_REG(CHECK_ZERO_REG)) u_check (
      .clk        (Clk),
      .reset      (Reset),
      .clear      (launch),
      .cmp_en     (cmp_en),
      .phase      (state_q),
      .addr1      (rreg1_q),
      .addr2      (rreg2_q),
      .rd_data1   (ReadData1),
      .rd_data2   (ReadData2),
      .exp1       (exp1),
      .exp2       (exp2),
      .mismatch1  (mismatch1),
      .mismatch2  (mismatch2),
      .fail_seen  (fail_seen),
      .fail_phase (FailPhase),
      .fail_addr  (FailAddr),
      .fail_port  (FailPort)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      done_d     = done_q;
      passed_d   = passed_q;
      wdata_d    = wdata_q;
      rreg1_d    = rreg1_q;
      rreg2_d    = rreg2_q;
      wreg_d     = wreg_q;
      regwrite_d = regwrite_q;
      launch     = 1'b0;
      nxt_state  = state_q;
      nxt_idx    = idx_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               launch    = 1'b1;
               nxt_state = ST_WR_A;
               nxt_idx   = '0;
            end
         end
         default: begin
            nxt_idx = idx_q + ADDR_W'(1);
            if (idx_q == LAST_IDX) nxt_state = next_phase(state_q);
            if (STOP_ON_FAIL && (mismatch1 || mismatch2)) nxt_state = ST_DONE;
         end
      endcase

      state_d = nxt_state;
      idx_d   = nxt_idx;

      if (launch) begin
         busy_d   = 1'b1;
         done_d   = 1'b0;
         passed_d = 1'b0;
      end

      // Port values are computed for the step being entered, keeping every output registered.
      case (nxt_state)
         ST_WR_A, ST_WR_B, ST_WR_HOLD: begin
            wreg_d     = nxt_idx;
            wdata_d    = pattern_a(nxt_idx, SEED);
            if (nxt_state == ST_WR_B) wdata_d = ~wdata_d;
            regwrite_d = (nxt_state != ST_WR_HOLD);
         end
         ST_RD_A, ST_RD_B, ST_RD_HOLD: begin
            regwrite_d = 1'b0;
            rreg1_d    = nxt_idx;
            rreg2_d    = ~nxt_idx;
         end
         default: ;
      endcase

      if ((nxt_state == ST_DONE) && (state_q != ST_DONE)) begin
         busy_d     = 1'b0;
         done_d     = 1'b1;
         passed_d   = !(fail_seen || mismatch1 || mismatch2);
         regwrite_d = 1'b0;
         idx_d      = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         passed_q   <= 1'b0;
         wdata_q    <= '0;
         rreg1_q    <= '0;
         rreg2_q    <= '0;
         wreg_q     <= '0;
         regwrite_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         passed_q   <= passed_d;
         wdata_q    <= wdata_d;
         rreg1_q    <= rreg1_d;
         rreg2_q    <= rreg2_d;
         wreg_q     <= wreg_d;
         regwrite_q <= regwrite_d;
      end
   end

   assign Busy          = busy_q;
   assign Done          = done_q;
   assign Passed        = passed_q;
   assign WriteData     = wdata_q;
   assign ReadRegister1 = rreg1_q;
   assign ReadRegister2 = rreg2_q;
   assign WriteRegister = wreg_q;
   assign RegWrite      = regwrite_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: three parameter variants, each beside a register file
// model with selectable faults; a march-level reference model predicts the outcome.
module tb_regfile_bist;

   localparam int NI = 3;
   localparam logic [31:0] SEED = 32'hA5C3_0F96;
   localparam int W = 44;

   localparam int F_NONE      = 0;
   localparam int F_HARD42    = 1;
   localparam int F_IGNORE_WE = 2;
   localparam int F_R0_WR     = 3;
   localparam int F_P2_STUCK0 = 4;
   localparam int F_STUCK_BIT = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   int   fault_mode = F_NONE;
   int   f_reg = 0;
   int   f_bit = 0;
   logic f_val = 1'b0;
   logic [W-1:0] exp_q[$];

   logic        start      [NI];
   logic        busy       [NI];
   logic        done       [NI];
   logic        passed     [NI];
   logic [2:0]  fail_phase [NI];
   logic [4:0]  fail_addr  [NI];
   logic        fail_port  [NI];
   logic [31:0] wdata      [NI];
   logic [4:0]  rr1        [NI];
   logic [4:0]  rr2        [NI];
   logic [4:0]  wr         [NI];
   logic        regw       [NI];

   function automatic logic [31:0] pat_a(input int a);
      return SEED ^ (32'(a) << 27) ^ 32'(a);
   endfunction

   // What a (possibly faulty) register file returns for a stored value.
   function automatic logic [31:0] fault_read(input logic [31:0] raw, input int a, input int port,
                                              input int mode, input int freg, input int fbit,
                                              input logic fval);
      logic [31:0] v;
      if (mode == F_HARD42) return 32'd42;
      if (mode == F_P2_STUCK0 && port == 1) return 32'd0;
      v = (a == 0 && mode != F_R0_WR) ? 32'd0 : raw;
      if (mode == F_STUCK_BIT && a == freg) v[fbit] = fval;
      return v;
   endfunction

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         logic [31:0] mem [32];
         logic [31:0] rd1_l, rd2_l;

         regfile_bist #(.SEED(SEED), .CHECK_ZERO_REG(g != 1), .STOP_ON_FAIL(g == 2)) dut (
            .Clk           (clk),
            .Reset         (reset),
            .Start         (start[g]),
            .Busy          (busy[g]),
            .Done          (done[g]),
            .Passed        (passed[g]),
            .FailPhase     (fail_phase[g]),
            .FailAddr      (fail_addr[g]),
            .FailPort      (fail_port[g]),
            .ReadData1     (rd1_l),
            .ReadData2     (rd2_l),
            .WriteData     (wdata[g]),
            .ReadRegister1 (rr1[g]),
            .ReadRegister2 (rr2[g]),
            .WriteRegister (wr[g]),
            .RegWrite      (regw[g])
         );

         always @(posedge clk) begin
            if (regw[g] || fault_mode == F_IGNORE_WE)
               if (wr[g] != 5'd0 || fault_mode == F_R0_WR) mem[wr[g]] <= wdata[g];
         end

         always @* begin
            rd1_l = fault_read(mem[rr1[g]], int'(rr1[g]), 0, fault_mode, f_reg, f_bit, f_val);
            rd2_l = fault_read(mem[rr2[g]], int'(rr2[g]), 1, fault_mode, f_reg, f_bit, f_val);
         end
      end
   endgenerate

   // March reference: apply all writes and reads in order, record the first miscompare.
   function automatic logic [W-1:0] model(input int g, input int s);
      logic [31:0] m [32];
      logic [31:0] want;
      bit          pass;
      bit          cz;
      bit          sof;
      logic [2:0]  ph;
      logic [4:0]  fa;
      logic        fp;
      int          lat;
      int          a;
      pass = 1'b1; cz = (g != 1); sof = (g == 2);
      ph = '0; fa = '0; fp = 1'b0; lat = 192;
      for (int k = 0; k < 32; k++) m[k] = '0;
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 32; i++) begin
            if (p % 2 == 0) begin
               if ((p != 4 || fault_mode == F_IGNORE_WE) && (i != 0 || fault_mode == F_R0_WR))
                  m[i] = (p == 2) ? ~pat_a(i) : pat_a(i);
            end else begin
               for (int port = 0; port < 2; port++) begin
                  a = (port == 0) ? i : 31 - i;
                  want = (a == 0) ? 32'd0 : ((p == 1) ? pat_a(a) : ~pat_a(a));
                  if (pass && (a != 0 || cz) &&
                      fault_read(m[a], a, port, fault_mode, f_reg, f_bit, f_val) != want) begin
                     pass = 1'b0;
                     ph = 3'(p);
                     fa = 5'(a);
                     fp = 1'(port);
                     if (sof) lat = 32 * p + i + 1;
                  end
               end
            end
         end
      end
      return {2'(g), 32'(s + lat), pass, ph, fa, fp};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Monitor: on each Done rise, pop the oldest prediction and compare.
   initial begin : monitor
      logic         done_prev [NI];
      logic [W-1:0] e;
      for (int g = 0; g < NI; g++) done_prev[g] = 1'b0;
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (done[g] && !done_prev[g]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done inst=%0d got=done want=idle", g);
               end else begin
                  e = exp_q.pop_front();
                  check("done_instance", 64'(g), 64'(e[43:42]));
                  check("done_cycle", 64'(cyc), 64'(e[41:10]));
                  check("passed", 64'(passed[g]), 64'(e[9]));
                  check("fail_diag", 64'({fail_phase[g], fail_addr[g], fail_port[g]}), 64'(e[8:0]));
                  check("busy_at_done", 64'(busy[g]), 64'd0);
                  check("regwrite_at_done", 64'(regw[g]), 64'd0);
               end
            end
            done_prev[g] = done[g];
         end
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL run_timeout got=pending(%0d) want=done", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run(input int g, input int mode);
      logic [W-1:0] e;
      fault_mode = mode;
      f_reg = $urandom_range(0, 31);
      f_bit = $urandom_range(0, 31);
      f_val = 1'($urandom_range(0, 1));
      @(negedge clk);
      e = model(g, cyc + 1);
      exp_q.push_back(e);
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      check("busy_after_start", 64'({busy[g], done[g]}), 64'b10);
      wait_drain();
      repeat (2) @(negedge clk);
      check("done_held", 64'({done[g], passed[g], regw[g]}), 64'({1'b1, e[9], 1'b0}));
   endtask

   task automatic reset_mid_run();
      int s;
      fault_mode = F_NONE;
      @(negedge clk);
      s = cyc + 1;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      while (cyc < s + 49) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_mid_run", 64'({busy[0], done[0], regw[0]}), 64'd0);
      run(0, F_NONE);
   endtask

   task automatic start_held();
      int n = 0;
      fault_mode = F_NONE;
      @(negedge clk);
      exp_q.push_back(model(0, cyc + 1));
      start[0] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!done[0] && n < 400);
      if (!done[0]) begin
         start[0] = 1'b0;
         wait_drain();
      end else begin
         exp_q.push_back(model(0, cyc + 1));
         @(negedge clk);
         check("restart_from_done", 64'({done[0], busy[0]}), 64'b01);
         start[0] = 1'b0;
         wait_drain();
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int g = 0; g < NI; g++) start[g] = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < NI; g++)
         check("reset_values", 64'({busy[g], done[g], passed[g], fail_phase[g], fail_addr[g],
                                    fail_port[g], wdata[g], rr1[g], rr2[g], wr[g], regw[g]}), 64'd0);
      reset = 1'b0;

      run(0, F_NONE);
      run(0, F_HARD42);
      run(1, F_HARD42);
      run(0, F_IGNORE_WE);
      run(2, F_IGNORE_WE);
      run(0, F_R0_WR);
      run(0, F_P2_STUCK0);
      run(2, F_NONE);
      reset_mid_run();
      start_held();

      repeat (12) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run($urandom_range(0, NI - 1), $urandom_range(F_NONE, F_STUCK_BIT));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
